conv_opctrl_seq: RTL and testbench

- Next-generation opcode-driven convolution control unit. It is parametrised in pixel width and kernel size, and adds valid/ready handshaking.
- It stores a KxK signed kernel from the shared bus.
- It accepts a KxK unsigned pixel window and computes the dot product with a sequential one-tap-per-cycle MAC.
- It holds the result until the downstream consumer accepts it.
- Position: between the host/opcode bus and the result/output buffer of the CAU.

---
 rtl/conv_pkg.sv | 25 ++
 rtl/conv_mac.sv | 46 ++++
 rtl/conv_opctrl_seq.sv | 127 ++++++++++++
 tb/tb_conv_opctrl_seq.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conv_pkg : opcodes, FSM states and accumulator sizing for conv_opctrl_seq |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package conv_pkg;

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_LOAD_K = 2'b01;
  localparam logic [1:0] OP_CONV   = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Signed product width plus enough headroom for K*K accumulations.
  function automatic int acc_width(input int dw, input int k);
    return 2 * dw + 1 + $clog2(k * k);
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_mac.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conv_mac : one-tap signed weight x unsigned pixel multiply-accumulate    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module conv_mac #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 21
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] w_i,
  input  logic [DATA_W-1:0] p_i,
  output logic [ACC_W-1:0]  acc_o
);

  localparam int PW = 2 * DATA_W + 1;

  logic [PW-1:0]    w_ext;
  logic [PW-1:0]    p_ext;
  logic [PW-1:0]    w_prod;
  logic [ACC_W-1:0] w_prod_ext;
  logic [ACC_W-1:0] acc_q;

  // Both operands widened to the full product width so the multiply is exact.
  assign w_ext      = {{(DATA_W + 1){w_i[DATA_W-1]}}, w_i};
  assign p_ext      = {{(DATA_W + 1){1'b0}}, p_i};
  assign w_prod     = $signed(w_ext) * $signed(p_ext);
  assign w_prod_ext = {{(ACC_W - PW){w_prod[PW-1]}}, w_prod};

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_q + w_prod_ext;
    end
  end

  assign acc_o = acc_q;

endmodule
`default_nettype wire

// File: rtl/conv_opctrl_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conv_opctrl_seq : opcode-driven KxK convolution, sequential MAC,         |
// | valid/ready result. Optional macro CONV_RELU_EN clamps negatives to 0.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module conv_opctrl_seq
  import conv_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int K      = 3,
  parameter int ACC_W  = acc_width(DATA_W, K)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  select,
  input  logic [1:0]            opcode,
  input  logic [K*K*DATA_W-1:0] bus,
  output logic                  cmd_ready,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_W-1:0]      result
);

  localparam int TAPS = K * K;
  localparam int TW   = (TAPS > 1) ? $clog2(TAPS) : 1;

  state_t            state_q;
  logic [TW-1:0]     tap_q;
  logic              last_q;
  logic              out_valid_q;
  logic [ACC_W-1:0]  result_q;
  logic [ACC_W-1:0]  result_d;
  logic [DATA_W-1:0] kern_q [TAPS];
  logic [DATA_W-1:0] win_q  [TAPS];
  logic [ACC_W-1:0]  w_acc;
  logic              w_accept;
  logic              w_mac_clr;
  logic              w_mac_en;

  assign w_accept  = select && (opcode != OP_NOP) && (state_q == ST_IDLE);
  assign w_mac_clr = w_accept && (opcode == OP_CONV);
  assign w_mac_en  = (state_q == ST_MAC) && !last_q;

  conv_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clr_i (w_mac_clr),
    .en_i  (w_mac_en),
    .w_i   (kern_q[tap_q]),
    .p_i   (win_q[tap_q]),
    .acc_o (w_acc)
  );

`ifdef CONV_RELU_EN
  assign result_d = w_acc[ACC_W-1] ? '0 : w_acc;
`else
  assign result_d = w_acc;
`endif

  // The cycle after the last tap (last_q) only moves the settled accumulator into result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      tap_q       <= '0;
      last_q      <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      for (int i = 0; i < TAPS; i++) begin
        kern_q[i] <= '0;
        win_q[i]  <= '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_accept) begin
            case (opcode)
              OP_LOAD_K: begin
                for (int i = 0; i < TAPS; i++) kern_q[i] <= bus[i*DATA_W +: DATA_W];
              end
              OP_CLEAR: begin
                for (int i = 0; i < TAPS; i++) kern_q[i] <= '0;
              end
              OP_CONV: begin
                for (int i = 0; i < TAPS; i++) win_q[i] <= bus[i*DATA_W +: DATA_W];
                tap_q   <= '0;
                last_q  <= 1'b0;
                state_q <= ST_MAC;
              end
              default: ;
            endcase
          end
        end
        ST_MAC: begin
          if (last_q) begin
            last_q      <= 1'b0;
            result_q    <= result_d;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else if (tap_q == TW'(TAPS - 1)) begin
            last_q <= 1'b1;
          end else begin
            tap_q <= tap_q + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_MAC) || (state_q == ST_DONE);
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_opctrl_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_conv_opctrl_seq : scoreboard bench with a dot-product reference model |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_conv_opctrl_seq;

  localparam int DW = 8;
  localparam int T  = 9;
  localparam int AW = 21;
  localparam logic [1:0] NOP = 2'b00;
  localparam logic [1:0] LDK = 2'b01;
  localparam logic [1:0] CNV = 2'b10;
  localparam logic [1:0] CLR = 2'b11;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          select = 1'b0;
  logic [1:0]    opcode = 2'b00;
  logic [T*DW-1:0] bus = '0;
  logic          out_ready = 1'b1;
  logic          cmd_ready;
  logic          busy;
  logic          out_valid;
  logic [AW-1:0] result;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic [AW-1:0] exp_q [$];
  logic [DW-1:0] mk [T];

  conv_opctrl_seq dut (
    .clk       (clk),
    .rst       (rst),
    .select    (select),
    .opcode    (opcode),
    .bus       (bus),
    .cmd_ready (cmd_ready),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [T*DW-1:0] rnd_bus();
    return {$urandom, $urandom, $urandom};
  endfunction

  function automatic logic [T*DW-1:0] fill(input logic [DW-1:0] v);
    logic [T*DW-1:0] b;
    for (int i = 0; i < T; i++) b[i*DW +: DW] = v;
    return b;
  endfunction

  // Reference: plain signed-weight x unsigned-pixel dot product.
  function automatic logic [AW-1:0] expect_of(input logic [T*DW-1:0] win);
    longint s;
    logic [DW-1:0] px;
    s = 0;
    for (int i = 0; i < T; i++) begin
      px = win[i*DW +: DW];
      s += longint'($signed(mk[i])) * longint'(px);
    end
`ifdef CONV_RELU_EN
    if (s < 0) s = 0;
`endif
    return AW'(s);
  endfunction

  // Monitor: every transfer pops one expected result.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got result %0h, required no transfer", result);
      end else begin
        check("result", result, exp_q.pop_front());
      end
    end
  end

  // Entered and left at #1 after a rising edge.
  task automatic issue(input logic sel, input logic [1:0] op, input logic [T*DW-1:0] b,
                       input bit push);
    int n;
    n = 0;
    while (!cmd_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) check("cmd_ready_wait", cmd_ready, 1);
    select = sel;
    opcode = op;
    bus    = b;
    @(posedge clk); #1;
    acc_cyc = cyc;
    select = 1'b0;
    opcode = NOP;
    bus    = rnd_bus();
    if (sel) begin
      case (op)
        LDK: for (int i = 0; i < T; i++) mk[i] = b[i*DW +: DW];
        CLR: for (int i = 0; i < T; i++) mk[i] = '0;
        CNV: if (push) exp_q.push_back(expect_of(b));
        default: ;
      endcase
    end
  endtask

  task automatic run_conv(input logic [T*DW-1:0] w, input int hold);
    int n;
    int start;
    logic [AW-1:0] want;
    want = expect_of(w);
    out_ready = (hold == 0);
    issue(1'b1, CNV, w, 1'b1);
    start = acc_cyc;
    n = 0;
    while (!out_valid && n < 30) begin
      check("busy_flags", {cmd_ready, busy}, 2'b01);
      @(posedge clk); #1;
      n++;
    end
    check("latency", cyc - start, 10);
    check("done_flags", {out_valid, cmd_ready, busy}, 3'b101);
    for (int h = 0; h < hold; h++) begin
      select = 1'b1;
      opcode = CNV;
      bus    = rnd_bus();
      @(posedge clk); #1;
      check("held_result", result, want);
      check("held_flags", {out_valid, cmd_ready}, 2'b10);
    end
    select    = 1'b0;
    opcode    = NOP;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_transfer", {out_valid, cmd_ready, busy}, 3'b010);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    for (int i = 0; i < T; i++) mk[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_flags", {out_valid, cmd_ready, busy}, 3'b010);
    check("reset_result", result, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    run_conv(72'h010203040506070809, 0);            // zero kernel after reset
    issue(1'b1, LDK, fill(8'h01), 1'b0);
    run_conv(72'h010203040506070809, 0);            // 45
    issue(1'b1, LDK, 72'h0000000000000000FF, 1'b0);
    run_conv(72'h000000000000000009, 0);            // -9 or 0 with ReLU
    run_conv(rnd_bus(), 5);                         // backpressure
    issue(1'b1, LDK, fill(8'h7F), 1'b0);
    run_conv(fill(8'hFF), 0);
    issue(1'b1, LDK, fill(8'h80), 1'b0);
    run_conv(fill(8'hFF), 0);

    // Reset during MAC discards the in-flight result and the kernel.
    issue(1'b1, CNV, rnd_bus(), 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < T; i++) mk[i] = '0;
    check("midmac_rst_flags", {out_valid, cmd_ready, busy}, 3'b010);
    check("midmac_rst_result", result, 0);
    run_conv(rnd_bus(), 0);

    issue(1'b1, LDK, fill(8'h01), 1'b0);
    issue(1'b1, CLR, rnd_bus(), 1'b0);
    run_conv(rnd_bus(), 0);
    issue(1'b1, LDK, fill(8'h01), 1'b0);
    issue(1'b0, LDK, rnd_bus(), 1'b0);
    run_conv(rnd_bus(), 0);

    for (int it = 0; it < 30; it++) begin
      r = $urandom_range(0, 5);
      case (r)
        0:       issue(1'b1, LDK, rnd_bus(), 1'b0);
        1:       issue(1'b1, CLR, rnd_bus(), 1'b0);
        2, 3:    run_conv(rnd_bus(), $urandom_range(0, 2));
        4:       issue(1'b0, 2'($urandom_range(0, 3)), rnd_bus(), 1'b0);
        default: issue(1'b1, NOP, rnd_bus(), 1'b0);
      endcase
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
